// File: rtl/noc_local_ni.sv
// Local network interface between a PE and a noc_router Local port: single-flit TX packer and FWFT RX buffer.
// Optional NI_STATS_EN macro adds tx_count/rx_count/drop_count statistics outputs.
module noc_local_ni #(
  parameter int WIDTH    = 16,
  parameter int RX_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  input  logic [1:0]       tx_dst,
  input  logic [WIDTH-4:0] tx_payload,
  output logic             tx_ready,
  output logic             net_write,
  output logic [WIDTH-1:0] net_data,
  input  logic             net_full,
  input  logic             net_almost_full,
  input  logic             rx_write,
  input  logic [WIDTH-1:0] rx_data,
  output logic             rx_full,
  output logic             rx_almost_full,
  output logic             rx_valid,
  output logic [1:0]       rx_dst,
  output logic [WIDTH-4:0] rx_payload,
  input  logic             rx_ready,
  output logic             rx_drop_err
`ifdef NI_STATS_EN
  ,
  output logic [15:0]      tx_count,
  output logic [15:0]      rx_count,
  output logic [7:0]       drop_count
`endif
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {TX_EMPTY, TX_LOADED} tx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [WIDTH-1:0] hold_flit_q, hold_flit_d;
  logic             can_send_q, can_send_d;
  logic             hold_vld;
  logic             tx_accept;

  assign hold_vld  = (tx_state_q == TX_LOADED);
  assign net_write = hold_vld & can_send_q;
  assign net_data  = net_write ? hold_flit_q : '0;
  assign tx_ready  = ~hold_vld | net_write;
  assign tx_accept = tx_valid & tx_ready;

  // can_send lags the router flags by one edge, so a write already in flight when almost_full rises also closes the gate
  always_comb begin
    tx_state_d  = tx_state_q;
    hold_flit_d = hold_flit_q;
    can_send_d  = ~((net_almost_full & net_write) | net_full);
    case (tx_state_q)
      TX_EMPTY: begin
        if (tx_accept) begin
          hold_flit_d = {tx_payload, tx_dst, 1'b1};
          tx_state_d  = TX_LOADED;
        end
      end
      TX_LOADED: begin
        if (tx_accept) begin
          hold_flit_d = {tx_payload, tx_dst, 1'b1};
          tx_state_d  = TX_LOADED;
        end else if (net_write) begin
          tx_state_d = TX_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q  <= TX_EMPTY;
      hold_flit_q <= '0;
      can_send_q  <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      hold_flit_q <= hold_flit_d;
      can_send_q  <= can_send_d;
    end
  end

  // The valid bit is implied for stored flits, so the RX buffer only keeps dst and payload
  logic [WIDTH-2:0] mem_q [RX_DEPTH];
  logic [WIDTH-2:0] mem_d [RX_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             drop_err_q, drop_err_d;
  logic             push, pop, push_ok, drop;

  assign rx_valid       = (count_q != '0);
  assign rx_full        = (count_q == CW'(RX_DEPTH));
  assign rx_almost_full = (count_q >= CW'(RX_DEPTH - 2));
  assign rx_dst         = rx_valid ? mem_q[rd_ptr_q][1:0] : '0;
  assign rx_payload     = rx_valid ? mem_q[rd_ptr_q][WIDTH-2:2] : '0;
  assign rx_drop_err    = drop_err_q;

  assign push    = rx_write & rx_data[0];
  assign pop     = rx_valid & rx_ready;
  assign push_ok = push & (~rx_full | pop);
  assign drop    = push & rx_full & ~pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_err_d = drop_err_q | drop;
    if (push_ok) begin
      mem_d[wr_ptr_q] = rx_data[WIDTH-1:1];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

`ifdef NI_STATS_EN
  logic [15:0] tx_count_q, tx_count_d;
  logic [15:0] rx_count_q, rx_count_d;
  logic [7:0]  drop_count_q, drop_count_d;

  assign tx_count   = tx_count_q;
  assign rx_count   = rx_count_q;
  assign drop_count = drop_count_q;

  always_comb begin
    tx_count_d   = tx_count_q + {15'd0, net_write};
    rx_count_d   = rx_count_q + {15'd0, push_ok};
    drop_count_d = drop_count_q + {7'd0, drop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count_q   <= '0;
      rx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      tx_count_q   <= tx_count_d;
      rx_count_q   <= rx_count_d;
      drop_count_q <= drop_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed self-checking bench for noc_local_ni (WIDTH=16, RX_DEPTH=8).
module tb_noc_local_ni;

  logic        clk;
  logic        reset;
  logic        tx_valid;
  logic [1:0]  tx_dst;
  logic [12:0] tx_payload;
  logic        tx_ready;
  logic        net_write;
  logic [15:0] net_data;
  logic        net_full;
  logic        net_almost_full;
  logic        rx_write;
  logic [15:0] rx_data;
  logic        rx_full;
  logic        rx_almost_full;
  logic        rx_valid;
  logic [1:0]  rx_dst;
  logic [12:0] rx_payload;
  logic        rx_ready;
  logic        rx_drop_err;
`ifdef NI_STATS_EN
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic [7:0]  drop_count;
`endif

  int checks = 0;
  int errors = 0;

  noc_local_ni #(.WIDTH(16), .RX_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_dst(tx_dst), .tx_payload(tx_payload), .tx_ready(tx_ready),
    .net_write(net_write), .net_data(net_data), .net_full(net_full), .net_almost_full(net_almost_full),
    .rx_write(rx_write), .rx_data(rx_data), .rx_full(rx_full), .rx_almost_full(rx_almost_full),
    .rx_valid(rx_valid), .rx_dst(rx_dst), .rx_payload(rx_payload), .rx_ready(rx_ready),
    .rx_drop_err(rx_drop_err)
`ifdef NI_STATS_EN
    , .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [15:0] mk_flit(input logic [12:0] p, input logic [1:0] d);
    return {p, d, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_valid = 1'b0; tx_dst = '0; tx_payload = '0;
    net_full = 1'b0; net_almost_full = 1'b0;
    rx_write = 1'b0; rx_data = '0; rx_ready = 1'b0;
    tick(); tick();
    checks++; if (net_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_net_write: got %b expected 0", net_write); end
    checks++; if (net_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_net_data: got %h expected 0000", net_data); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    checks++; if ({rx_valid, rx_full, rx_almost_full, rx_drop_err} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_rx_flags: got %b expected 0000", {rx_valid, rx_full, rx_almost_full, rx_drop_err}); end
    checks++; if ({rx_dst, rx_payload} !== 15'h0) begin errors++; $display("[TB] FAIL reset_rx_head: got %h expected 0", {rx_dst, rx_payload}); end
    reset = 1'b0;
    checks++; if (net_write !== 1'b0) begin errors++; $display("[TB] FAIL release_net_write: got %b expected 0", net_write); end
    tick();
  endtask

  task automatic test_basic_tx();
    tx_valid = 1'b1; tx_dst = 2'b01; tx_payload = 13'h0ABC;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_tx_ready: got %b expected 1", tx_ready); end
    tick();
    tx_valid = 1'b0;
    checks++; if (net_write !== 1'b1) begin errors++; $display("[TB] FAIL basic_tx_write: got %b expected 1", net_write); end
    checks++; if (net_data !== 16'h55E3) begin errors++; $display("[TB] FAIL basic_tx_data: got %h expected 55e3", net_data); end
    tick();
    checks++; if (net_write !== 1'b0) begin errors++; $display("[TB] FAIL basic_tx_no_extra: got %b expected 0", net_write); end
    checks++; if (net_data !== 16'h0) begin errors++; $display("[TB] FAIL basic_tx_idle_data: got %h expected 0000", net_data); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_dst = 2'(i); tx_payload = 13'h100 + 13'(i);
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_tx_ready[%0d]: got %b expected 1", i, tx_ready); end
      if (i > 0) begin
        exp = mk_flit(13'h100 + 13'(i - 1), 2'(i - 1));
        checks++; if (net_write !== 1'b1 || net_data !== exp) begin
          errors++; $display("[TB] FAIL b2b_flit[%0d]: got write=%b data=%h expected write=1 data=%h", i - 1, net_write, net_data, exp); end
      end
      tick();
    end
    tx_valid = 1'b0;
    exp = mk_flit(13'h103, 2'd3);
    checks++; if (net_write !== 1'b1 || net_data !== exp) begin
      errors++; $display("[TB] FAIL b2b_flit[3]: got write=%b data=%h expected write=1 data=%h", net_write, net_data, exp); end
    tick();
    checks++; if (net_write !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end: got %b expected 0", net_write); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_a, exp_b;
    exp_a = mk_flit(13'h0AAA, 2'b10);
    exp_b = mk_flit(13'h1BBB, 2'b11);
    tx_valid = 1'b1; tx_dst = 2'b10; tx_payload = 13'h0AAA; net_almost_full = 1'b1;
    tick();
    checks++; if (net_write !== 1'b1 || net_data !== exp_a) begin
      errors++; $display("[TB] FAIL bp_first: got write=%b data=%h expected write=1 data=%h", net_write, net_data, exp_a); end
    tx_dst = 2'b11; tx_payload = 13'h1BBB;
    tick();
    checks++; if ({net_write, tx_ready} !== 2'b00 || net_data !== 16'h0) begin
      errors++; $display("[TB] FAIL bp_stall_af: got write=%b ready=%b data=%h expected 0 0 0000", net_write, tx_ready, net_data); end
    tx_dst = 2'b00; tx_payload = 13'h0CCC; net_almost_full = 1'b0; net_full = 1'b1;
    tick();
    checks++; if ({net_write, tx_ready} !== 2'b00) begin
      errors++; $display("[TB] FAIL bp_stall_full: got write=%b ready=%b expected 0 0", net_write, tx_ready); end
    net_full = 1'b0;
    tick();
    tx_valid = 1'b0;
    checks++; if (net_write !== 1'b1 || net_data !== exp_b) begin
      errors++; $display("[TB] FAIL bp_resume: got write=%b data=%h expected write=1 data=%h", net_write, net_data, exp_b); end
    tick();
    checks++; if (net_write !== 1'b0) begin errors++; $display("[TB] FAIL bp_end: got %b expected 0", net_write); end
  endtask

  task automatic test_rx_fill();
    logic exp_af, exp_full;
    rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx_write = 1'b1; rx_data = mk_flit(13'h10 + 13'(i), 2'(i));
      tick();
      exp_af = (i >= 5); exp_full = (i == 7);
      checks++; if (rx_almost_full !== exp_af || rx_full !== exp_full) begin
        errors++; $display("[TB] FAIL rx_fill_flags[%0d]: got af=%b full=%b expected af=%b full=%b", i, rx_almost_full, rx_full, exp_af, exp_full); end
    end
    checks++; if ({rx_valid, rx_dst, rx_payload, rx_drop_err} !== {1'b1, 2'd0, 13'h10, 1'b0}) begin
      errors++; $display("[TB] FAIL rx_full_head: got v=%b d=%b p=%h err=%b expected v=1 d=00 p=0010 err=0", rx_valid, rx_dst, rx_payload, rx_drop_err); end
    rx_data = mk_flit(13'h18, 2'd0); rx_ready = 1'b1;
    tick();
    checks++; if ({rx_full, rx_drop_err, rx_dst, rx_payload} !== {1'b1, 1'b0, 2'd1, 13'h11}) begin
      errors++; $display("[TB] FAIL rx_push_pop_full: got full=%b err=%b d=%b p=%h expected full=1 err=0 d=01 p=0011", rx_full, rx_drop_err, rx_dst, rx_payload); end
    rx_ready = 1'b0; rx_data = mk_flit(13'h1F, 2'd3);
    tick();
    rx_write = 1'b0;
    checks++; if ({rx_drop_err, rx_full, rx_payload} !== {1'b1, 1'b1, 13'h11}) begin
      errors++; $display("[TB] FAIL rx_drop: got err=%b full=%b p=%h expected err=1 full=1 p=0011", rx_drop_err, rx_full, rx_payload); end
  endtask

  task automatic test_rx_drain();
    logic [12:0] exp_p;
    logic [1:0]  exp_d;
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_p = 13'h11 + 13'(i); exp_d = 2'(i + 1);
      checks++; if (rx_valid !== 1'b1 || rx_payload !== exp_p || rx_dst !== exp_d) begin
        errors++; $display("[TB] FAIL rx_drain[%0d]: got v=%b d=%b p=%h expected v=1 d=%b p=%h", i, rx_valid, rx_dst, rx_payload, exp_d, exp_p); end
      tick();
    end
    checks++; if ({rx_valid, rx_almost_full, rx_dst, rx_payload} !== 17'h0) begin
      errors++; $display("[TB] FAIL rx_drained: got v=%b af=%b d=%b p=%h expected all 0", rx_valid, rx_almost_full, rx_dst, rx_payload); end
    rx_write = 1'b1; rx_data = 16'h7FFE;
    tick();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rx_invalid_flit: got %b expected 0", rx_valid); end
    rx_data = mk_flit(13'h0123, 2'b10);
    tick();
    rx_write = 1'b0;
    checks++; if ({rx_valid, rx_dst, rx_payload} !== {1'b1, 2'b10, 13'h0123}) begin
      errors++; $display("[TB] FAIL rx_empty_push_pop: got v=%b d=%b p=%h expected v=1 d=10 p=0123", rx_valid, rx_dst, rx_payload); end
    tick();
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rx_last_pop: got %b expected 0", rx_valid); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_write = 1'b1; rx_data = mk_flit(13'h0200 + 13'(i), 2'd0);
      tick();
    end
    rx_write = 1'b0;
    tx_valid = 1'b1; tx_dst = 2'b01; tx_payload = 13'h0777;
    tick();
    tx_valid = 1'b0;
    checks++; if ({net_write, rx_valid, rx_drop_err} !== 3'b111) begin
      errors++; $display("[TB] FAIL mid_before_reset: got write=%b rxv=%b err=%b expected 1 1 1", net_write, rx_valid, rx_drop_err); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({net_write, rx_valid, rx_drop_err} !== 3'b000 || net_data !== 16'h0) begin
      errors++; $display("[TB] FAIL mid_reset_outputs: got write=%b rxv=%b err=%b data=%h expected 0 0 0 0000", net_write, rx_valid, rx_drop_err, net_data); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_tx_ready: got %b expected 1", tx_ready); end
    tick();
    reset = 1'b0;
    tx_valid = 1'b1; tx_dst = 2'b11; tx_payload = 13'h1234;
    checks++; if (net_write !== 1'b0) begin errors++; $display("[TB] FAIL mid_release_write: got %b expected 0", net_write); end
    tick();
    tx_valid = 1'b0;
    exp = mk_flit(13'h1234, 2'b11);
    checks++; if (net_write !== 1'b1 || net_data !== exp) begin
      errors++; $display("[TB] FAIL mid_first_write: got write=%b data=%h expected write=1 data=%h", net_write, net_data, exp); end
    tick();
    checks++; if (net_write !== 1'b0) begin errors++; $display("[TB] FAIL mid_end: got %b expected 0", net_write); end
  endtask

  initial begin
    test_reset();
    test_basic_tx();
    test_back_to_back();
    test_backpressure();
    test_rx_fill();
    test_rx_drain();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
